// File: rtl/lcd_timing_gen_if.sv
// LCD pin bundle: data enable, syncs and RGB.
// Master drives the panel pins, slave observes them.
interface lcd_timing_gen_if #(
  parameter int R_W = 5,
  parameter int G_W = 6,
  parameter int B_W = 5
);
  logic           lcd_de;
  logic           lcd_hsync;
  logic           lcd_vsync;
  logic [R_W-1:0] lcd_r;
  logic [G_W-1:0] lcd_g;
  logic [B_W-1:0] lcd_b;

  modport master (
    output lcd_de,
    output lcd_hsync,
    output lcd_vsync,
    output lcd_r,
    output lcd_g,
    output lcd_b
  );

  modport slave (
    input lcd_de,
    input lcd_hsync,
    input lcd_vsync,
    input lcd_r,
    input lcd_g,
    input lcd_b
  );
endinterface

// File: rtl/lcd_timing_gen.sv
// RGB-LCD timing and test-pattern generator.
// Outputs are registered from the pre-increment raster position.
module lcd_timing_gen #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 48,
  parameter int H_BP     = 40,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 13,
  parameter int V_SYNC   = 3,
  parameter int V_BP     = 29,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int R_W      = 5,
  parameter int G_W      = 6,
  parameter int B_W      = 5,
  parameter int GRID     = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_ce,
  input  logic [1:0] mode,
  lcd_timing_gen_if.master lcd,
  output logic [$clog2(H_ACTIVE+H_FP+H_SYNC+H_BP)-1:0] pix_x,
  output logic [$clog2(V_ACTIVE+V_FP+V_SYNC+V_BP)-1:0] pix_y,
  output logic       frame_start,
  output logic [7:0] frame_cnt
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int BW      = (H_ACTIVE / 8 < 1) ? 1 : H_ACTIVE / 8;
  localparam int BCW     = $clog2(BW + 1);
  localparam int GCW     = $clog2(GRID);
  localparam int HS_ON   = H_ACTIVE + H_FP;
  localparam int HS_OFF  = HS_ON + H_SYNC;
  localparam int VS_ON   = V_ACTIVE + V_FP;
  localparam int VS_OFF  = VS_ON + V_SYNC;
  localparam logic HS_ACT = 1'(HS_POL);
  localparam logic VS_ACT = 1'(VS_POL);

  logic [HW-1:0]  h, h_nxt;
  logic [VW-1:0]  v, v_nxt;
  logic [1:0]     mode_q, mode_eff;
  logic [BCW-1:0] bar_cnt, bar_cnt_nxt;
  logic [2:0]     bar_idx, bar_idx_nxt;
  logic [GCW-1:0] gx, gx_nxt;
  logic [GCW-1:0] gy, gy_nxt;
  logic [7:0]     fc_nxt;

  logic           org, h_last, v_last;
  logic           de_n, hs_n, vs_n;
  logic [R_W-1:0] r_n, r_q;
  logic [G_W-1:0] g_n, g_q;
  logic [B_W-1:0] b_n, b_q;
  logic           de_q, hs_q, vs_q;

  assign org      = (h == '0) && (v == '0);
  assign h_last   = 32'(h) == H_TOTAL - 1;
  assign v_last   = 32'(v) == V_TOTAL - 1;
  assign mode_eff = org ? mode : mode_q;
  assign fc_nxt   = org ? frame_cnt + 8'd1 : frame_cnt;

  assign de_n = (32'(h) < H_ACTIVE) && (32'(v) < V_ACTIVE);
  assign hs_n = (32'(h) >= HS_ON) && (32'(h) < HS_OFF);
  assign vs_n = (32'(v) >= VS_ON) && (32'(v) < VS_OFF);

  assign lcd.lcd_de    = de_q;
  assign lcd.lcd_hsync = hs_q;
  assign lcd.lcd_vsync = vs_q;
  assign lcd.lcd_r     = r_q;
  assign lcd.lcd_g     = g_q;
  assign lcd.lcd_b     = b_q;

  // Raster, bar and grid counters advance together per pixel tick.
  always_comb begin : count_next
    h_nxt       = h;
    v_nxt       = v;
    bar_cnt_nxt = bar_cnt;
    bar_idx_nxt = bar_idx;
    gx_nxt      = gx;
    gy_nxt      = gy;
    if (h_last) begin
      h_nxt       = '0;
      bar_cnt_nxt = '0;
      bar_idx_nxt = '0;
      gx_nxt      = '0;
      if (v_last) begin
        v_nxt  = '0;
        gy_nxt = '0;
      end else begin
        v_nxt  = v + 1'b1;
        gy_nxt = (32'(gy) == GRID - 1) ? '0 : gy + 1'b1;
      end
    end else begin
      h_nxt  = h + 1'b1;
      gx_nxt = (32'(gx) == GRID - 1) ? '0 : gx + 1'b1;
      if (32'(bar_cnt) == BW - 1) begin
        bar_cnt_nxt = '0;
        if (bar_idx != 3'd7) bar_idx_nxt = bar_idx + 3'd1;
      end else begin
        bar_cnt_nxt = bar_cnt + 1'b1;
      end
    end
  end

  // Pattern colour for the current position, blanked outside DE.
  always_comb begin : pixel_next
    r_n = '0;
    g_n = '0;
    b_n = '0;
    if (de_n) begin
      unique case (mode_eff)
        2'd0: begin
          r_n = '1;
          g_n = '1;
          b_n = '1;
        end
        2'd1: begin
          r_n = {R_W{~bar_idx[1]}};
          g_n = {G_W{~bar_idx[2]}};
          b_n = {B_W{~bar_idx[0]}};
        end
        2'd2: begin
          r_n = R_W'(h >> 2);
          g_n = G_W'(v >> 1);
          b_n = B_W'(fc_nxt);
        end
        2'd3: begin
          if (gx == '0 || gy == '0) begin
            r_n = '1;
            g_n = '1;
            b_n = '1;
          end
        end
        default: ;
      endcase
    end
  end

  // State and output registers, updated only on pixel ticks.
  always_ff @(posedge clk or posedge rst) begin : regs
    if (rst) begin
      h           <= '0;
      v           <= '0;
      mode_q      <= '0;
      bar_cnt     <= '0;
      bar_idx     <= '0;
      gx          <= '0;
      gy          <= '0;
      frame_cnt   <= '0;
      frame_start <= 1'b0;
      de_q        <= 1'b0;
      hs_q        <= ~HS_ACT;
      vs_q        <= ~VS_ACT;
      r_q         <= '0;
      g_q         <= '0;
      b_q         <= '0;
      pix_x       <= '0;
      pix_y       <= '0;
    end else begin
      frame_start <= 1'b0;
      if (pix_ce) begin
        h           <= h_nxt;
        v           <= v_nxt;
        mode_q      <= mode_eff;
        bar_cnt     <= bar_cnt_nxt;
        bar_idx     <= bar_idx_nxt;
        gx          <= gx_nxt;
        gy          <= gy_nxt;
        frame_cnt   <= fc_nxt;
        frame_start <= org;
        de_q        <= de_n;
        hs_q        <= hs_n ? HS_ACT : ~HS_ACT;
        vs_q        <= vs_n ? VS_ACT : ~VS_ACT;
        r_q         <= r_n;
        g_q         <= g_n;
        b_q         <= b_n;
        pix_x       <= h;
        pix_y       <= v;
      end
    end
  end
endmodule

// File: tb/tb_lcd_timing_gen.sv
// Directed bench for lcd_timing_gen on a 24x8 raster.
// u0 uses active-low syncs, u1 active-high HSYNC.
module tb_lcd_timing_gen;
  logic       clk = 1'b0;
  logic       rst;
  logic       pix_ce;
  logic       pix_ce1;
  logic [1:0] mode;
  logic [1:0] mode1;
  logic [4:0] px0, px1;
  logic [2:0] py0, py1;
  logic       fs0, fs1;
  logic [7:0] fc0, fc1;
  int vectors = 0;
  int miscompares = 0;

  logic [2:0] bars [8] = '{3'b111, 3'b110, 3'b011, 3'b010,
                           3'b101, 3'b100, 3'b001, 3'b000};

  lcd_timing_gen_if #(.R_W(5), .G_W(6), .B_W(5)) if0 ();
  lcd_timing_gen_if #(.R_W(5), .G_W(6), .B_W(5)) if1 ();

  lcd_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(0), .VS_POL(0), .R_W(5), .G_W(6), .B_W(5), .GRID(4)
  ) u0 (
    .clk(clk), .rst(rst), .pix_ce(pix_ce), .mode(mode), .lcd(if0),
    .pix_x(px0), .pix_y(py0), .frame_start(fs0), .frame_cnt(fc0)
  );

  lcd_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1), .VS_POL(0), .R_W(5), .G_W(6), .B_W(5), .GRID(4)
  ) u1 (
    .clk(clk), .rst(rst), .pix_ce(pix_ce1), .mode(mode1), .lcd(if1),
    .pix_x(px1), .pix_y(py1), .frame_start(fs1), .frame_cnt(fc1)
  );

  wire [35:0] obs0 = {if0.lcd_de, if0.lcd_hsync, if0.lcd_vsync, fs0,
                      px0, py0, fc0, if0.lcd_r, if0.lcd_g, if0.lcd_b};
  wire [19:0] obs1 = {if1.lcd_de, if1.lcd_hsync, if1.lcd_vsync, fs1,
                      px1, py1, fc1};

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    pix_ce  = 1'b0;
    pix_ce1 = 1'b0;
    rst     = 1'b1;
    step();
    step();
    rst     = 1'b0;
  endtask

  task automatic test_reset;
    mode  = 2'd0;
    mode1 = 2'd0;
    do_reset();
    vectors++;
    if (obs0 !== {4'b0110, 32'h0}) begin
      miscompares++;
      $display("FAIL reset_u0 got=%h want=%h", obs0, {4'b0110, 32'h0});
    end
    vectors++;
    if (obs1 !== {4'b0010, 16'h0}) begin
      miscompares++;
      $display("FAIL reset_u1 got=%h want=%h", obs1, {4'b0010, 16'h0});
    end
  endtask

  task automatic test_timing;
    logic [35:0] e;
    logic de;
    int x, y, nde, nvs;
    nde = 0;
    nvs = 0;
    do_reset();
    mode   = 2'd0;
    pix_ce = 1'b1;
    for (int t = 0; t <= 192; t++) begin
      step();
      x  = t % 24;
      y  = (t / 24) % 8;
      de = (x < 16) && (y < 4);
      e  = {de, !(x >= 18 && x < 21), !(y >= 5 && y < 7),
            (t % 192) == 0, 5'(x), 3'(y), 8'(1 + t / 192),
            de ? 16'hffff : 16'h0};
      vectors++;
      if (obs0 !== e) begin
        miscompares++;
        $display("FAIL timing t=%0d got=%h want=%h", t, obs0, e);
      end
      if (t < 24 && obs0[35]) nde++;
      if (t < 192 && !obs0[33]) nvs++;
    end
    vectors++;
    if (nde !== 16) begin
      miscompares++;
      $display("FAIL de_count got=%0d want=16", nde);
    end
    vectors++;
    if (nvs !== 48) begin
      miscompares++;
      $display("FAIL vsync_count got=%0d want=48", nvs);
    end
  endtask

  task automatic test_ce_div;
    logic [19:0] e;
    int n, x, y, first, second;
    first  = -1;
    second = -1;
    do_reset();
    for (int k = 0; k <= 576; k++) begin
      pix_ce1 = (k % 3) == 0;
      step();
      n = k / 3;
      x = n % 24;
      y = (n / 24) % 8;
      e = {(x < 16) && (y < 4), (x >= 18 && x < 21),
           !(y >= 5 && y < 7), ((k % 3) == 0) && ((n % 192) == 0),
           5'(x), 3'(y), 8'(1 + n / 192)};
      vectors++;
      if (obs1 !== e) begin
        miscompares++;
        $display("FAIL ce_div k=%0d got=%h want=%h", k, obs1, e);
      end
      if (fs1 && first < 0) first = k;
      else if (fs1 && second < 0) second = k;
    end
    pix_ce1 = 1'b0;
    vectors++;
    if (second - first !== 576) begin
      miscompares++;
      $display("FAIL fs_period got=%0d want=576", second - first);
    end
  endtask

  task automatic test_bars;
    logic [15:0] e, got;
    logic [2:0] c;
    do_reset();
    mode   = 2'd1;
    pix_ce = 1'b1;
    for (int x = 0; x < 24; x++) begin
      step();
      c = (x < 16) ? bars[x / 2] : 3'b000;
      e = {c[2] ? 5'd31 : 5'd0, c[1] ? 6'd63 : 6'd0, c[0] ? 5'd31 : 5'd0};
      got = obs0[15:0];
      vectors++;
      if (got !== e || px0 !== 5'(x)) begin
        miscompares++;
        $display("FAIL bars x=%0d got=%h/%0d want=%h/%0d", x, got, px0, e, x);
      end
    end
  endtask

  task automatic test_mode_latch;
    logic [23:0] e;
    logic on;
    int x, y;
    do_reset();
    mode   = 2'd0;
    pix_ce = 1'b1;
    for (int t = 0; t < 384; t++) begin
      step();
      if (t == 48) mode = 2'd3;
      x = t % 24;
      y = (t / 24) % 8;
      if (t < 192) on = (x < 16) && (y < 4);
      else on = (x < 16) && (y < 4) && ((x % 4) == 0 || y == 0);
      e = {5'(x), 3'(y), on ? 16'hffff : 16'h0};
      vectors++;
      if ({px0, py0, obs0[15:0]} !== e) begin
        miscompares++;
        $display("FAIL mode_latch t=%0d got=%h want=%h", t,
                 {px0, py0, obs0[15:0]}, e);
      end
    end
  endtask

  task automatic test_gradient;
    logic [23:0] e;
    int x, y, f;
    do_reset();
    mode   = 2'd2;
    pix_ce = 1'b1;
    for (int t = 0; t < 576; t++) begin
      step();
      x = t % 24;
      y = (t / 24) % 8;
      f = t / 192 + 1;
      e = {8'(f), ((x < 16) && (y < 4)) ?
           {5'(x / 4), 6'(y / 2), 5'(f)} : 16'h0};
      vectors++;
      if ({fc0, obs0[15:0]} !== e) begin
        miscompares++;
        $display("FAIL gradient t=%0d got=%h want=%h", t,
                 {fc0, obs0[15:0]}, e);
      end
    end
  endtask

  task automatic test_reset_mid;
    do_reset();
    mode   = 2'd0;
    pix_ce = 1'b1;
    repeat (80) step();
    vectors++;
    if ({px0, py0} !== {5'd7, 3'd3}) begin
      miscompares++;
      $display("FAIL mid_pos got=%0d,%0d want=7,3", px0, py0);
    end
    #1;
    rst = 1'b1;
    #1;
    vectors++;
    if (obs0 !== {4'b0110, 32'h0}) begin
      miscompares++;
      $display("FAIL mid_async got=%h want=%h", obs0, {4'b0110, 32'h0});
    end
    step();
    step();
    vectors++;
    if (obs0 !== {4'b0110, 32'h0}) begin
      miscompares++;
      $display("FAIL mid_hold got=%h want=%h", obs0, {4'b0110, 32'h0});
    end
    rst = 1'b0;
    step();
    vectors++;
    if (obs0 !== {4'b1111, 5'd0, 3'd0, 8'd1, 16'hffff}) begin
      miscompares++;
      $display("FAIL mid_restart got=%h want=%h", obs0,
               {4'b1111, 5'd0, 3'd0, 8'd1, 16'hffff});
    end
  endtask

  task automatic test_wrap;
    do_reset();
    mode   = 2'd0;
    pix_ce = 1'b1;
    step();
    vectors++;
    if ({fs0, fc0} !== {1'b1, 8'd1}) begin
      miscompares++;
      $display("FAIL wrap_first got=%b/%0d want=1/1", fs0, fc0);
    end
    repeat (254 * 192) step();
    vectors++;
    if ({fs0, fc0} !== {1'b1, 8'd255}) begin
      miscompares++;
      $display("FAIL wrap_255 got=%b/%0d want=1/255", fs0, fc0);
    end
    repeat (192) step();
    vectors++;
    if ({fs0, fc0} !== {1'b1, 8'd0}) begin
      miscompares++;
      $display("FAIL wrap_0 got=%b/%0d want=1/0", fs0, fc0);
    end
  endtask

  initial begin
    rst     = 1'b1;
    pix_ce  = 1'b0;
    pix_ce1 = 1'b0;
    mode    = 2'd0;
    mode1   = 2'd0;
    test_reset();
    test_timing();
    test_ce_div();
    test_bars();
    test_mode_latch();
    test_gradient();
    test_reset_mid();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
